// File: rtl/basicgates_bist.sv
`default_nettype none
// ============================================================================
//  Module   : basicgates_bist
//  Purpose  : Self-test controller for a two-input basic-gate block. Sweeps
//             all four {a,b} vectors, checks the six gate outputs and reports
//             pass/fail, a saturating error count and the first failure.
//  Revision : 1.0 - initial release
// ============================================================================
module basicgates_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4,
    parameter bit LOOP          = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             andc,
    input  logic             orc,
    input  logic             nandc,
    input  logic             norc,
    input  logic             xorc,
    input  logic             xnorc,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       fail_vec,
    output logic [5:0]       fail_mask
);

    localparam int c_CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST =
        c_CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q;
    logic [1:0]         vec_q;
    logic [c_CNT_W-1:0] settle_q;
    logic               sweep_err_q;

    logic [5:0]         w_expected;
    logic [5:0]         w_actual;
    logic [5:0]         w_diff;
    logic               w_mismatch;
    logic [ERR_W-1:0]   err_cnt_d;

    always_comb begin
        w_expected = {a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
        w_actual   = {andc, orc, nandc, norc, xorc, xnorc};
        w_diff     = w_expected ^ w_actual;
        w_mismatch = |w_diff;
        err_cnt_d  = (err_cnt == {ERR_W{1'b1}}) ? err_cnt : err_cnt + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= 2'd0;
            settle_q    <= '0;
            sweep_err_q <= 1'b0;
            a           <= 1'b0;
            b           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
            fail_vec    <= 2'd0;
            fail_mask   <= 6'd0;
        end else begin
            // In loop mode done is a single-cycle pulse.
            if (LOOP) begin
                done <= 1'b0;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_cnt     <= '0;
                        fail_vec    <= 2'd0;
                        fail_mask   <= 6'd0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        vec_q       <= 2'd0;
                        sweep_err_q <= 1'b0;
                        busy        <= 1'b1;
                        state_q     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    a        <= vec_q[1];
                    b        <= vec_q[0];
                    settle_q <= '0;
                    state_q  <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == c_SETTLE_LAST) begin
                        settle_q <= '0;
                        state_q  <= S_CHECK;
                    end else begin
                        settle_q <= settle_q + c_CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        err_cnt     <= err_cnt_d;
                        sweep_err_q <= 1'b1;
                        // Zero count means nothing captured since start; fail_* persist across loop sweeps.
                        if (err_cnt == '0) begin
                            fail_vec  <= vec_q;
                            fail_mask <= w_diff;
                        end
                    end
                    if (vec_q == 2'd3) begin
                        done        <= 1'b1;
                        pass        <= ~(sweep_err_q | w_mismatch);
                        sweep_err_q <= 1'b0;
                        vec_q       <= 2'd0;
                        if (LOOP) begin
                            state_q <= S_DRIVE;
                        end else begin
                            busy    <= 1'b0;
                            a       <= 1'b0;
                            b       <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end else begin
                        vec_q   <= vec_q + 2'd1;
                        state_q <= S_DRIVE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_basicgates_bist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_basicgates_bist
//  Purpose  : Self-checking bench for basicgates_bist across four parameter
//             sets, with a faulty gate-block model and a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_basicgates_bist;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] start;

    logic [3:0][5:0] stk;
    logic [3:0][5:0] inv;
    wire  [3:0][5:0] g;

    wire [3:0]       ao, bo, busy, done, pass;
    wire [3:0][3:0]  ec;
    wire [3:0][1:0]  fv;
    wire [3:0][5:0]  fm;

    int per  [4] = '{4, 4, 2, 4};
    int errw [4] = '{4, 1, 4, 4};

    int total  = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Gate truth table from arithmetic on the input sum.
    function automatic logic [5:0] ideal(input logic ia, input logic ib);
        int  s;
        logic an, o, x;
        s  = int'(ia) + int'(ib);
        an = (s == 2);
        o  = (s >= 1);
        x  = (s == 1);
        return {an, o, !an, !o, x, !x};
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_gate
        assign g[i] = (ideal(ao[i], bo[i]) & ~stk[i]) ^ inv[i];
    end

    assign ec[1][3:1] = 3'b000;

    basicgates_bist #(.SETTLE_CYCLES(2), .ERR_W(4), .LOOP(1'b0)) u_def (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .andc(g[0][5]), .orc(g[0][4]), .nandc(g[0][3]), .norc(g[0][2]), .xorc(g[0][1]), .xnorc(g[0][0]),
        .a(ao[0]), .b(bo[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_cnt(ec[0]), .fail_vec(fv[0]), .fail_mask(fm[0]));

    basicgates_bist #(.SETTLE_CYCLES(2), .ERR_W(1), .LOOP(1'b0)) u_e1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .andc(g[1][5]), .orc(g[1][4]), .nandc(g[1][3]), .norc(g[1][2]), .xorc(g[1][1]), .xnorc(g[1][0]),
        .a(ao[1]), .b(bo[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_cnt(ec[1][0]), .fail_vec(fv[1]), .fail_mask(fm[1]));

    basicgates_bist #(.SETTLE_CYCLES(0), .ERR_W(4), .LOOP(1'b0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start[2]),
        .andc(g[2][5]), .orc(g[2][4]), .nandc(g[2][3]), .norc(g[2][2]), .xorc(g[2][1]), .xnorc(g[2][0]),
        .a(ao[2]), .b(bo[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_cnt(ec[2]), .fail_vec(fv[2]), .fail_mask(fm[2]));

    basicgates_bist #(.SETTLE_CYCLES(2), .ERR_W(4), .LOOP(1'b1)) u_lp (
        .clk(clk), .rst_n(rst_n), .start(start[3]),
        .andc(g[3][5]), .orc(g[3][4]), .nandc(g[3][3]), .norc(g[3][2]), .xorc(g[3][1]), .xnorc(g[3][0]),
        .a(ao[3]), .b(bo[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
        .err_cnt(ec[3]), .fail_vec(fv[3]), .fail_mask(fm[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected sweep outcome: walk the four vectors with the fault applied.
    task automatic model(input logic [5:0] s, input logic [5:0] n, input int w,
                         output int e, output logic [1:0] v, output logic [5:0] m,
                         output logic p);
        logic [5:0] ex, ac;
        e = 0; v = 2'd0; m = 6'd0;
        for (int k = 0; k < 4; k++) begin
            ex = ideal(k[1], k[0]);
            ac = (ex & ~s) ^ n;
            if (ac != ex) begin
                if (e == 0) begin
                    v = k[1:0];
                    m = ac ^ ex;
                end
                e++;
            end
        end
        p = (e == 0);
        if (e > (1 << w) - 1) e = (1 << w) - 1;
    endtask

    task automatic chk_zero(input int d);
        chk($sformatf("reset_outs_%0d", d),
            {15'd0, ao[d], bo[d], busy[d], done[d], pass[d], ec[d], fv[d], fm[d]}, 32'd0);
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk); start[d] = 1'b1;
        @(negedge clk); start[d] = 1'b0;
    endtask

    task automatic run_sweep(input int d, input int repulse, input int exp_lat);
        int cyc;
        pulse_start(d);
        chk("busy_after_start", busy[d], 1);
        chk("done_cleared", done[d], 0);
        cyc = 0;
        while (done[d] !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start[d] = (cyc == repulse);
            if (cyc % per[d] == 1 && cyc / per[d] < 4)
                chk("ab_seq", {30'd0, ao[d], bo[d]}, cyc / per[d]);
        end
        start[d] = 1'b0;
        chk("done_latency", cyc, exp_lat);
    endtask

    task automatic chk_result(input int d);
        int e; logic [1:0] v; logic [5:0] m; logic p;
        model(stk[d], inv[d], errw[d], e, v, m, p);
        chk("err_cnt", ec[d], e);
        chk("fail_vec", fv[d], v);
        chk("fail_mask", fm[d], m);
        chk("pass", pass[d], p);
        chk("busy_end", busy[d], 0);
        chk("ab_end", {ao[d], bo[d]}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 4'd0;
        stk   = '0;
        inv   = '0;
        #1;
        for (int d = 0; d < 4; d++) chk_zero(d);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Ideal gates, default parameters
        run_sweep(0, 0, 16);
        chk_result(0);

        // Re-pulsed start mid-sweep is ignored
        run_sweep(0, 5, 16);
        chk_result(0);

        // XOR stuck at 0
        stk[0] = 6'b000010;
        run_sweep(0, 0, 16);
        chk_result(0);
        stk[0] = '0;

        // ERR_W=1 with every output inverted saturates at 1
        inv[1] = 6'b111111;
        run_sweep(1, 0, 16);
        chk_result(1);
        inv[1] = '0;

        // Randomized fault patterns on both the wide and narrow counters
        for (int i = 0; i < 10; i++) begin
            int d;
            d = i % 2;
            stk[d] = 6'($urandom_range(0, 63));
            inv[d] = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            run_sweep(d, 0, 16);
            chk_result(d);
        end
        stk = '0;
        inv = '0;

        // SETTLE_CYCLES=0: failing sweep, then a clean one clears history
        inv[2] = 6'b000001;
        run_sweep(2, 0, 8);
        chk_result(2);
        inv[2] = '0;
        run_sweep(2, 0, 8);
        chk_result(2);

        // Asynchronous reset mid-sweep, then a fresh clean sweep
        pulse_start(0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero(0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 0, 16);
        chk_result(0);

        // LOOP=1: done pulses every 16 cycles, busy stays high
        pulse_start(3);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            chk("loop_busy", busy[3], 1);
            chk("loop_done", done[3], (cyc % 16 == 0));
            if (cyc % 16 == 0) chk("loop_pass", pass[3], 1);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
